// File: rtl/cpu_exec_sequencer_pkg.sv
// Shared definitions for the moxie issue/sequence controller: state encodings,
// the opcode values it cares about, and opcode classification helpers.
package cpu_exec_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE     = 2'd0,
        SEQ_STEP     = 2'd1,
        SEQ_DIV_WAIT = 2'd2,
        SEQ_FLUSH    = 2'd3
    } seq_state_t;

    // Opcode values follow the moxie ISA encodings.
    localparam logic [5:0] OP_MOV    = 6'h02;
    localparam logic [5:0] OP_JSRA   = 6'h03;
    localparam logic [5:0] OP_RET    = 6'h04;
    localparam logic [5:0] OP_ADD_L  = 6'h05;
    localparam logic [5:0] OP_NOP    = 6'h0F;
    localparam logic [5:0] OP_JSR    = 6'h19;
    localparam logic [5:0] OP_XOR    = 6'h2E;
    localparam logic [5:0] OP_DIV_L  = 6'h31;
    localparam logic [5:0] OP_UDIV_L = 6'h32;
    localparam logic [5:0] OP_MOD_L  = 6'h33;
    localparam logic [5:0] OP_UMOD_L = 6'h34;

    function automatic logic is_two_step(input logic [5:0] op);
        return (op == OP_JSR) || (op == OP_JSRA) || (op == OP_RET);
    endfunction

    function automatic logic is_div(input logic [5:0] op);
        return (op == OP_DIV_L) || (op == OP_UDIV_L) ||
               (op == OP_MOD_L) || (op == OP_UMOD_L);
    endfunction

endpackage

// File: rtl/cpu_exec_sequencer_flush_timer.sv
// Loadable down-counter that holds flush_o high for a programmed number of
// cycles after each load; a reload while running restarts the window.
module cpu_exec_sequencer_flush_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_load,
    input  logic [2:0] i_cycles,
    output logic       o_flush,
    output logic       o_last
);

    logic [2:0] r_cnt;
    logic       r_flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= 3'd0;
            r_flush <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= i_cycles;
            r_flush <= 1'b1;
        end else begin
            if (r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            // Flush stays up while at least one more cycle remains after this one.
            r_flush <= (r_cnt > 3'd1);
        end
    end

    assign o_flush = r_flush;
    assign o_last  = (r_cnt == 3'd1);

endmodule

// File: rtl/cpu_exec_sequencer.sv
// Issue/sequence controller ahead of the moxie execute stage: expands
// multi-cycle ops into numbered micro-steps, stalls decode, and drives flush.
module cpu_exec_sequencer
    import cpu_exec_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int DIV_TIMEOUT  = 40
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [5:0] op_i,
    output logic       ready_o,
    output logic       exec_valid_o,
    output logic [5:0] exec_op_o,
    output logic [1:0] step_o,
    output logic       stall_o,
    output logic       div_start_o,
    input  logic       div_done_i,
    input  logic       branch_taken_i,
    output logic       flush_o,
    output logic       div_err_o,
    output logic [1:0] dbg_state_o
);

    // Handshake: an op transfers on a cycle where valid_i and ready_o are both
    // high; ready_o never depends on valid_i, and decode holds op_i until it does.

    localparam logic [2:0] FLUSH_N   = (FLUSH_CYCLES == 0) ? 3'd1 : 3'(FLUSH_CYCLES);
    localparam logic [7:0] TIMEOUT_N = 8'(DIV_TIMEOUT);

    seq_state_t r_state;
    seq_state_t w_next_state;

    logic       r_exec_valid;
    logic [5:0] r_exec_op;
    logic [1:0] r_step;
    logic       r_div_start;
    logic       r_div_err;
    logic [7:0] r_to;

    logic       w_issue;
    logic       w_issue_step1;
    logic       w_accept;
    logic       w_start;
    logic       w_err;
    logic       w_flush_last;
    logic [7:0] w_to_sat;

    assign w_to_sat = (r_to == 8'hFF) ? r_to : r_to + 8'd1;

    always_comb begin
        w_next_state  = r_state;
        w_issue       = 1'b0;
        w_issue_step1 = 1'b0;
        w_accept      = 1'b0;
        w_start       = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (valid_i && !branch_taken_i) begin
                    w_accept = 1'b1;
                    w_issue  = 1'b1;
                    if (is_two_step(op_i)) begin
                        w_next_state = SEQ_STEP;
                    end else if (is_div(op_i)) begin
                        w_start      = 1'b1;
                        w_next_state = SEQ_DIV_WAIT;
                    end
                end
            end
            SEQ_STEP: begin
                w_issue       = 1'b1;
                w_issue_step1 = 1'b1;
                w_next_state  = SEQ_IDLE;
            end
            SEQ_DIV_WAIT: begin
                if (div_done_i) begin
                    w_issue       = 1'b1;
                    w_issue_step1 = 1'b1;
                    w_next_state  = SEQ_IDLE;
                end else if (w_to_sat == TIMEOUT_N) begin
                    // An abandoning branch suppresses the error report.
                    w_err        = !branch_taken_i;
                    w_next_state = SEQ_IDLE;
                end
            end
            SEQ_FLUSH: begin
                if (w_flush_last) begin
                    w_next_state = SEQ_IDLE;
                end
            end
            default: w_next_state = SEQ_IDLE;
        endcase
        // A step-1 issue already decided above still goes out alongside the branch.
        if (branch_taken_i) begin
            w_next_state = SEQ_FLUSH;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= SEQ_IDLE;
            r_exec_valid <= 1'b0;
            r_exec_op    <= OP_NOP;
            r_step       <= 2'd0;
            r_div_start  <= 1'b0;
            r_div_err    <= 1'b0;
            r_to         <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_exec_valid <= w_issue;
            r_step       <= w_issue_step1 ? 2'd1 : 2'd0;
            r_div_start  <= w_start;
            r_div_err    <= w_err;
            if (w_accept) begin
                r_exec_op <= op_i;
            end
            if (w_start) begin
                r_to <= 8'd0;
            end else if (r_state == SEQ_DIV_WAIT) begin
                r_to <= w_to_sat;
            end
        end
    end

    cpu_exec_sequencer_flush_timer u_flush_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (branch_taken_i),
        .i_cycles (FLUSH_N),
        .o_flush  (flush_o),
        .o_last   (w_flush_last)
    );

    assign ready_o      = (r_state == SEQ_IDLE) && !branch_taken_i && !rst_i;
    assign stall_o      = (r_state == SEQ_STEP) || (r_state == SEQ_DIV_WAIT);
    assign exec_valid_o = r_exec_valid;
    assign exec_op_o    = r_exec_op;
    assign step_o       = r_step;
    assign div_start_o  = r_div_start;
    assign div_err_o    = r_div_err;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Self-checking bench for cpu_exec_sequencer: directed scenarios plus random
// traffic, scored against a behavioural model of the issue/flush/divide rules.
module tb_cpu_exec_sequencer;
  import cpu_exec_sequencer_pkg::*;

  localparam int FLUSH_CYCLES = 2;
  localparam int DIV_TIMEOUT  = 40;
  localparam int FLUSH_N      = (FLUSH_CYCLES == 0) ? 1 : FLUSH_CYCLES;

  logic       clk;
  logic       rst;
  logic       valid_i;
  logic [5:0] op_i;
  logic       ready_o;
  logic       exec_valid_o;
  logic [5:0] exec_op_o;
  logic [1:0] step_o;
  logic       stall_o;
  logic       div_start_o;
  logic       div_done_i;
  logic       branch_taken_i;
  logic       flush_o;
  logic       div_err_o;
  logic [1:0] dbg_state_o;

  cpu_exec_sequencer #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .DIV_TIMEOUT  (DIV_TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid_i),
    .op_i           (op_i),
    .ready_o        (ready_o),
    .exec_valid_o   (exec_valid_o),
    .exec_op_o      (exec_op_o),
    .step_o         (step_o),
    .stall_o        (stall_o),
    .div_start_o    (div_start_o),
    .div_done_i     (div_done_i),
    .branch_taken_i (branch_taken_i),
    .flush_o        (flush_o),
    .div_err_o      (div_err_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run    = 1'b0;
  int start_cyc = -1000;

  // expected issue: {cycle[15:0], op[5:0], step[1:0]}
  logic [23:0] exp_q[$];

  // ---------------- reference model state ----------------
  int         m_flush_left;
  bit         m_step_pend;
  bit         m_div_busy;
  int         m_div_age;
  logic [5:0] m_op;
  bit         e_flush, e_start, e_err;

  function automatic bit tb_two_step(input logic [5:0] op);
    case (op)
      8'h19, 8'h03, 8'h04: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic bit tb_div(input logic [5:0] op);
    return (op >= 6'h31) && (op <= 6'h34);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_flush_left = 0;
    m_step_pend  = 1'b0;
    m_div_busy   = 1'b0;
    m_div_age    = 0;
    m_op         = OP_NOP;
    e_flush      = 1'b0;
    e_start      = 1'b0;
    e_err        = 1'b0;
    cyc          = 0;
    start_cyc    = -1000;
    exp_q.delete();
  endtask

  // Model: decides, from the rules, what the sequencer shows after each edge.
  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      bit idle;
      cyc++;
      idle    = (m_flush_left == 0) && !m_step_pend && !m_div_busy;
      e_start = 1'b0;
      e_err   = 1'b0;
      if (m_step_pend) begin
        exp_q.push_back({16'(cyc), m_op, 2'd1});
        m_step_pend = 1'b0;
      end else if (m_div_busy) begin
        if (div_done_i) begin
          exp_q.push_back({16'(cyc), m_op, 2'd1});
          m_div_busy = 1'b0;
        end else begin
          m_div_age = (m_div_age < 255) ? m_div_age + 1 : 255;
          if (m_div_age == DIV_TIMEOUT) begin
            m_div_busy = 1'b0;
            e_err      = !branch_taken_i;
          end
        end
      end else if (idle && valid_i && !branch_taken_i) begin
        m_op = op_i;
        exp_q.push_back({16'(cyc), op_i, 2'd0});
        if (tb_two_step(op_i)) begin
          m_step_pend = 1'b1;
        end else if (tb_div(op_i)) begin
          m_div_busy = 1'b1;
          m_div_age  = 0;
          e_start    = 1'b1;
        end
      end
      if (branch_taken_i) begin
        m_flush_left = FLUSH_N;
        m_step_pend  = 1'b0;
        m_div_busy   = 1'b0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
      e_flush = (m_flush_left > 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (run && !rst) begin
      logic [23:0] item;
      bit idle_now;
      idle_now = (m_flush_left == 0) && !m_step_pend && !m_div_busy;
      check("ready", 32'(ready_o), 32'(idle_now && !branch_taken_i));
      check("stall", 32'(stall_o), 32'(m_step_pend || m_div_busy));
      check("flush", 32'(flush_o), 32'(e_flush));
      check("div_start", 32'(div_start_o), 32'(e_start));
      check("div_err", 32'(div_err_o), 32'(e_err));
      if (div_start_o) start_cyc = cyc;
      if (div_err_o) check("err_latency", 32'(cyc - start_cyc), 32'(DIV_TIMEOUT));
      while (exp_q.size() > 0 && exp_q[0][23:8] < 16'(cyc)) begin
        item = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL issue_missing cycle=%0d actual=none required=op %0h step %0d",
                 item[23:8], item[7:2], item[1:0]);
      end
      if (exec_valid_o) begin
        if (exp_q.size() > 0 && exp_q[0][23:8] == 16'(cyc)) begin
          item = exp_q.pop_front();
          check("exec_op", 32'(exec_op_o), 32'(item[7:2]));
          check("step", 32'(step_o), 32'(item[1:0]));
        end else begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected cycle=%0d actual=op %0h step %0d required=no issue",
                   cyc, exec_op_o, step_o);
        end
      end else if (exp_q.size() > 0 && exp_q[0][23:8] == 16'(cyc)) begin
        item = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL issue_missing cycle=%0d actual=none required=op %0h step %0d",
                 cyc, item[7:2], item[1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input bit v, input logic [5:0] op, input bit done, input bit br);
    valid_i        = v;
    op_i           = op;
    div_done_i     = done;
    branch_taken_i = br;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, OP_NOP, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_exec_valid"}, 32'(exec_valid_o), 32'd0);
    check({tag, "_exec_op"}, 32'(exec_op_o), 32'(OP_NOP));
    check({tag, "_step"}, 32'(step_o), 32'd0);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd0);
    check({tag, "_div_start"}, 32'(div_start_o), 32'd0);
    check({tag, "_div_err"}, 32'(div_err_o), 32'd0);
    check({tag, "_flush"}, 32'(flush_o), 32'd0);
    check({tag, "_state"}, 32'(dbg_state_o), 32'(SEQ_IDLE));
  endtask

  logic [5:0] op_pool[11];

  initial begin
    op_pool = '{OP_ADD_L, OP_MOV, OP_XOR, OP_NOP, OP_JSR, OP_JSRA, OP_RET,
                OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L};
    valid_i = 1'b0; op_i = OP_NOP; div_done_i = 1'b0; branch_taken_i = 1'b0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back single-step ops
    tick(1'b1, OP_ADD_L, 1'b0, 1'b0);
    tick(1'b1, OP_MOV,   1'b0, 1'b0);
    tick(1'b1, OP_XOR,   1'b0, 1'b0);
    idle_ticks(3);

    // JSR then a branch resolved on its step-1 cycle
    tick(1'b1, OP_JSR, 1'b0, 1'b0);
    tick(1'b0, OP_NOP, 1'b0, 1'b0);
    tick(1'b0, OP_NOP, 1'b0, 1'b1);
    idle_ticks(5);

    // divide completing after 10 cycles
    tick(1'b1, OP_DIV_L, 1'b0, 1'b0);
    idle_ticks(9);
    tick(1'b0, OP_NOP, 1'b1, 1'b0);
    idle_ticks(4);

    // divide timing out
    tick(1'b1, OP_UMOD_L, 1'b0, 1'b0);
    idle_ticks(DIV_TIMEOUT + 5);

    // branch beats a presented op, then a reload one cycle into the flush
    tick(1'b1, OP_ADD_L, 1'b0, 1'b1);
    tick(1'b1, OP_ADD_L, 1'b0, 1'b1);
    tick(1'b0, OP_NOP, 1'b0, 1'b0);
    tick(1'b0, OP_NOP, 1'b0, 1'b0);
    idle_ticks(3);

    // asynchronous reset in the middle of a divide wait
    tick(1'b1, OP_DIV_L, 1'b0, 1'b0);
    idle_ticks(5);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 9) < 7,
           op_pool[$urandom_range(0, 10)],
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 19) == 0);
    end

    idle_ticks(DIV_TIMEOUT + 10);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
